// File: rtl/corr_result_harvester.sv
// Harvests correlator results: round-robin over pending channels, reads Cnt/Low/High/Status
// over the shared register bus and streams 4-word records out of a local FIFO.
module corr_result_harvester #(
  parameter int          NCH        = 4,
  parameter logic [31:0] BASE_ADDR  = 32'hFE000630,
  parameter logic [31:0] CH_STRIDE  = 32'h00000010,
  parameter int          FIFO_WORDS = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] seen,
  input  logic           bus_grant,
  output logic [31:0]    m_addr,
  output logic           m_read,
  input  logic [31:0]    m_rdata,
  output logic [31:0]    rec_data,
  output logic           rec_valid,
  output logic           rec_last,
  input  logic           rec_ready,
  output logic           overrun,
  output logic [15:0]    drop_cnt
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = $clog2(FIFO_WORDS);
  localparam logic [AW:0] FILL_LIMIT = (AW+1)'(FIFO_WORDS - 4);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    RD_CNT  = 3'd2,
    RD_LOW  = 3'd3,
    RD_HIGH = 3'd4,
    RD_STAT = 3'd5
  } state_t;

  function automatic logic [3:0] ones(input logic [NCH-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NCH; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  state_t          state_r, state_s;
  logic [NCH-1:0]  seen_d_r, pending_r;
  logic            armed_r;
  logic [CW-1:0]   rr_ptr_r, sel_r;
  logic [15:0]     seq_r;
  logic            overrun_r;
  logic [15:0]     drop_cnt_r;
  logic [32:0]     fifo_mem_r [FIFO_WORDS];
  logic [AW:0]     wr_ptr_r, rd_ptr_r;

  logic [NCH-1:0]  rise_s, clr_s, over_hits_s;
  logic [16:0]     drop_sum_s;
  logic [15:0]     drop_next_s;
  logic            pick_found_s, pick_hit_s;
  logic [CW-1:0]   pick_sel_s, rr_next_s;
  logic [CW:0]     cand_s;
  logic            take_s, push_s, clr_pend_s, room_s, empty_s, pop_s;
  logic [32:0]     push_word_s, head_s;
  logic [AW:0]     fill_s;
  logic [31:0]     blk_addr_s;

  // Edge detection, pending bookkeeping inputs and saturating drop count.
  // armed_r masks the first cycle out of reset so a seen line left high is not re-captured.
  always_comb begin
    rise_s             = armed_r ? (seen & ~seen_d_r) : '0;
    clr_s              = '0;
    clr_s[sel_r]       = clr_pend_s;
    over_hits_s        = rise_s & pending_r;
    drop_sum_s         = {1'b0, drop_cnt_r} + {13'b0, ones(over_hits_s)};
    drop_next_s        = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
  end

  // Round-robin pick: first pending channel at or after rr_ptr_r, wrapping.
  always_comb begin
    pick_found_s = 1'b0;
    pick_hit_s   = 1'b0;
    pick_sel_s   = '0;
    cand_s       = '0;
    for (int i = 0; i < NCH; i++) begin
      cand_s       = {1'b0, rr_ptr_r} + (CW+1)'(i);
      cand_s       = (cand_s >= (CW+1)'(NCH)) ? (cand_s - (CW+1)'(NCH)) : cand_s;
      pick_hit_s   = ~pick_found_s & pending_r[cand_s[CW-1:0]];
      pick_sel_s   = pick_hit_s ? cand_s[CW-1:0] : pick_sel_s;
      pick_found_s = pick_found_s | pick_hit_s;
    end
    rr_next_s = (pick_sel_s == CW'(NCH-1)) ? '0 : (pick_sel_s + CW'(1));
  end

  assign fill_s     = wr_ptr_r - rd_ptr_r;
  assign empty_s    = (fill_s == '0);
  assign room_s     = (fill_s <= FILL_LIMIT);
  assign pop_s      = ~empty_s & rec_ready;
  assign head_s     = fifo_mem_r[rd_ptr_r[AW-1:0]];
  assign blk_addr_s = BASE_ADDR + (32'(sel_r) * CH_STRIDE);

  // Next-state, bus master strobes and FIFO push selection.
  always_comb begin
    state_s     = state_r;
    m_read      = 1'b0;
    m_addr      = 32'h0000_0000;
    push_s      = 1'b0;
    push_word_s = 33'h0_0000_0000;
    clr_pend_s  = 1'b0;
    take_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_found_s && room_s) begin
          take_s  = 1'b1;
          state_s = HDR;
        end else begin
          state_s = IDLE;
        end
      end
      HDR: begin
        push_s      = 1'b1;
        push_word_s = {1'b0, 8'hC0, 5'b00000, 3'(sel_r), seq_r};
        state_s     = RD_CNT;
      end
      RD_CNT: begin
        m_read = bus_grant;
        m_addr = blk_addr_s;
        if (bus_grant) begin
          push_s      = 1'b1;
          push_word_s = {1'b0, m_rdata};
          state_s     = RD_LOW;
        end else begin
          state_s = RD_CNT;
        end
      end
      RD_LOW: begin
        m_read = bus_grant;
        m_addr = blk_addr_s + 32'h4;
        if (bus_grant) begin
          push_s      = 1'b1;
          push_word_s = {1'b0, m_rdata};
          state_s     = RD_HIGH;
        end else begin
          state_s = RD_LOW;
        end
      end
      RD_HIGH: begin
        m_read = bus_grant;
        m_addr = blk_addr_s + 32'h8;
        if (bus_grant) begin
          push_s      = 1'b1;
          push_word_s = {1'b1, m_rdata};
          state_s     = RD_STAT;
        end else begin
          state_s = RD_HIGH;
        end
      end
      RD_STAT: begin
        m_read = bus_grant;
        m_addr = blk_addr_s + 32'hC;
        if (bus_grant) begin
          clr_pend_s = 1'b1;
          state_s    = IDLE;
        end else begin
          state_s = RD_STAT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, channel selection and record sequence number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      rr_ptr_r <= '0;
      sel_r    <= '0;
      seq_r    <= 16'h0000;
    end else begin
      state_r <= state_s;
      if (take_s) begin
        sel_r    <= pick_sel_s;
        rr_ptr_r <= rr_next_s;
      end
      if (state_r == HDR) begin
        seq_r <= seq_r + 16'd1;
      end
    end
  end

  // Event capture; a new edge on an already-pending channel wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_d_r   <= '0;
      armed_r    <= 1'b0;
      pending_r  <= '0;
      overrun_r  <= 1'b0;
      drop_cnt_r <= 16'h0000;
    end else begin
      seen_d_r  <= seen;
      armed_r   <= 1'b1;
      pending_r <= (pending_r & ~clr_s) | rise_s;
      if (|over_hits_s) begin
        overrun_r  <= 1'b1;
        drop_cnt_r <= drop_next_s;
      end
    end
  end

  // Record FIFO storage; contents are only observable while non-empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r[AW-1:0]] <= push_word_s;
    end
  end

  // Record FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  assign rec_valid = ~empty_s;
  assign rec_data  = empty_s ? 32'h0000_0000 : head_s[31:0];
  assign rec_last  = ~empty_s & head_s[32];
  assign overrun   = overrun_r;
  assign drop_cnt  = drop_cnt_r;

endmodule
